// File: rtl/mmio_interconnect.sv
// Memory-mapped interconnect between the core data port and NSLV slaves.
// Base/mask address decode, per-slave wait states via req_ready, sticky unmapped-access log.
module mmio_interconnect #(
    parameter int unsigned          NSLV = 3,
    parameter logic [NSLV*32-1:0]   BASE = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0]   MASK = {32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_F000},
    parameter logic [NSLV*4-1:0]    WAIT = {4'd2, 4'd0, 4'd0}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [2:0]           req_funct3,
    output logic                 req_ready,
    output logic [31:0]          rsp_rdata,
    output logic [NSLV-1:0]      slv_sel,
    output logic                 slv_we,
    output logic [31:0]          slv_addr,
    output logic [31:0]          slv_wdata,
    output logic [2:0]           slv_funct3,
    input  logic [NSLV*32-1:0]   slv_rdata,
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [31:0]          err_addr,
    output logic [7:0]           err_count
);

    localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic              hit_any;
    logic [IdxW-1:0]   hit_idx;
    logic [NSLV-1:0]   hit_onehot;
    logic [3:0]        hit_wait;
    logic [31:0]       hit_rdata;
    logic [NSLV-1:0]   lat_onehot;
    logic [31:0]       lat_rdata;
    logic              unmapped;

    assign slv_addr   = req_addr;
    assign slv_wdata  = req_wdata;
    assign slv_funct3 = req_funct3;

    // Scan from the top index down so the lowest-index hit overrides the rest.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        hit_wait   = '0;
        hit_rdata  = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((req_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
                hit_any       = 1'b1;
                hit_idx       = IdxW'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_wait      = WAIT[4*i +: 4];
                hit_rdata     = slv_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        lat_onehot = '0;
        lat_rdata  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (int'(idx_q) == i) begin
                lat_onehot[i] = 1'b1;
                lat_rdata     = slv_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        req_ready = 1'b1;
        rsp_rdata = '0;
        slv_sel   = '0;
        slv_we    = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && hit_any) begin
                        slv_sel = hit_onehot;
                        if (hit_wait == 4'd0) begin
                            slv_we    = req_we;
                            rsp_rdata = hit_rdata;
                        end else begin
                            req_ready = 1'b0;
                            cnt_d     = hit_wait - 4'd1;
                            idx_d     = hit_idx;
                            state_d   = StWait;
                        end
                    end
                end
                StWait: begin
                    slv_sel = lat_onehot;
                    if (cnt_q != 4'd0) begin
                        req_ready = 1'b0;
                        cnt_d     = cnt_q - 4'd1;
                    end else begin
                        // Strobe only on the completing cycle so a store lands once.
                        slv_we    = req_we;
                        rsp_rdata = lat_rdata;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign unmapped = !reset && (state_q == StIdle) && req_valid && !hit_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // A new error in the same cycle as err_clr wins and restarts the count at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (unmapped) begin
            err_valid <= 1'b1;
            err_addr  <= req_addr;
            if (err_clr) begin
                err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed self-checking bench for mmio_interconnect with the default 3-slave map.
module tb_mmio_interconnect;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic [31:0] rsp_rdata;
    logic [2:0]  slv_sel;
    logic        slv_we;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [2:0]  slv_funct3;
    logic [95:0] slv_rdata;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int we_pulses;

    mmio_interconnect dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .rsp_rdata  (rsp_rdata),
        .slv_sel    (slv_sel),
        .slv_we     (slv_we),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_funct3 (slv_funct3),
        .slv_rdata  (slv_rdata),
        .err_clr    (err_clr),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        err_clr    = 1'b0;
        req_funct3 = 3'b010;
        slv_rdata  = {32'h0000_1234, 32'hCAFE_0001, 32'hDEAD_BEEF};
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        tick();
        tick();
        check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_sel", {29'b0, slv_sel}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err_valid", {31'b0, err_valid}, 32'd0);
        check_eq("rst_err_count", {24'b0, err_count}, 32'd0);
        reset = 1'b0;

        // Zero-wait load from slave 0
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        check_eq("ld0_ready", {31'b0, req_ready}, 32'd1);
        check_eq("ld0_sel", {29'b0, slv_sel}, 32'b001);
        check_eq("ld0_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("ld0_we", {31'b0, slv_we}, 32'd0);
        check_eq("funct3_pass", {29'b0, slv_funct3}, 32'b010);
        tick();

        // Zero-wait store to the I/O window
        drive(1'b1, 1'b1, 32'h0000_1004, 32'h5);
        check_eq("st1_sel", {29'b0, slv_sel}, 32'b010);
        check_eq("st1_we", {31'b0, slv_we}, 32'd1);
        check_eq("st1_ready", {31'b0, req_ready}, 32'd1);
        check_eq("st1_wdata", slv_wdata, 32'h5);
        check_eq("st1_addr", slv_addr, 32'h0000_1004);
        tick();

        // 0x1010 falls outside the 16-byte I/O window and every other window
        drive(1'b1, 1'b0, 32'h0000_1010, 32'h0);
        check_eq("io_miss_sel", {29'b0, slv_sel}, 32'd0);
        check_eq("io_miss_rdata", rsp_rdata, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("io_miss_err_addr", err_addr, 32'h0000_1010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_err_count", {24'b0, err_count}, 32'd0);

        // Two-wait-state load from slave 2
        drive(1'b1, 1'b0, 32'h0000_2008, 32'h0);
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("ld2_ready_c%0d", c), {31'b0, req_ready}, (c == 2) ? 32'd1 : 32'd0);
            check_eq($sformatf("ld2_sel_c%0d", c), {29'b0, slv_sel}, 32'b100);
            if (c == 2) check_eq("ld2_rdata", rsp_rdata, 32'h0000_1234);
            tick();
        end

        // Wait-state store: strobe only in the completing cycle
        we_pulses = 0;
        drive(1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_0000);
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("st2_we_c%0d", c), {31'b0, slv_we}, (c == 2) ? 32'd1 : 32'd0);
            if (slv_we) we_pulses++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("st2_back_idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("st2_we_pulses", we_pulses, 32'd1);

        // Unmapped load
        drive(1'b1, 1'b0, 32'h0000_8000, 32'h0);
        check_eq("um_ready", {31'b0, req_ready}, 32'd1);
        check_eq("um_rdata", rsp_rdata, 32'd0);
        check_eq("um_sel", {29'b0, slv_sel}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("um_err_valid", {31'b0, err_valid}, 32'd1);
        check_eq("um_err_addr", err_addr, 32'h0000_8000);
        check_eq("um_err_count", {24'b0, err_count}, 32'd1);

        // Saturation after 300 more
        drive(1'b1, 1'b0, 32'h0000_8000, 32'h0);
        for (int n = 0; n < 300; n++) tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("sat_err_count", {24'b0, err_count}, 32'd255);

        // Clear together with a new unmapped access: new error wins
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_9000, 32'h0);
        tick();
        err_clr = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("clrhit_err_count", {24'b0, err_count}, 32'd1);
        check_eq("clrhit_err_addr", err_addr, 32'h0000_9000);
        check_eq("clrhit_err_valid", {31'b0, err_valid}, 32'd1);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_err_valid", {31'b0, err_valid}, 32'd0);
        check_eq("clr_err_addr", err_addr, 32'd0);

        // Reset during cycle 1 of a slave-2 store aborts it without a strobe
        drive(1'b1, 1'b1, 32'h0000_2000, 32'h7);
        check_eq("abort_we_c0", {31'b0, slv_we}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check_eq("abort_we_c1", {31'b0, slv_we}, 32'd0);
        check_eq("abort_sel_c1", {29'b0, slv_sel}, 32'd0);
        check_eq("abort_ready_c1", {31'b0, req_ready}, 32'd1);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("abort_idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("abort_err_count", {24'b0, err_count}, 32'd0);
        // A fresh wait-state access must start from IDLE again
        drive(1'b1, 1'b1, 32'h0000_2000, 32'h7);
        check_eq("abort_restart_ready", {31'b0, req_ready}, 32'd0);
        check_eq("abort_restart_we", {31'b0, slv_we}, 32'd0);
        tick();
        check_eq("abort_restart_c1_we", {31'b0, slv_we}, 32'd0);
        tick();
        check_eq("abort_restart_c2_we", {31'b0, slv_we}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
